pr_bridge: RTL and testbench
============================

PR_BRIDGE -- requirements
Module: pr_bridge

Interface
REQ-001 Parameter NUM_DEV, default 2, number of attached devices; legal range 1..6.
REQ-002 Parameter BASE_ADDR, default 32'h0000_7F00, byte address of device 0 window.
REQ-003 Parameter WIN_AW, default 4, log2 of each device window size in bytes; device i window = BASE_ADDR + i*2^WIN_AW.
REQ-004 Parameter TIMEOUT, default 16, maximum ACCESS cycles before error completion; legal range 2..255.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 PrReq / PrWe  in  1 / 1  CPU access request / write qualifier; held stable while PrStall=1.
REQ-008 PrAddr / PrWD  in  32 / 32  CPU byte address / write data.
REQ-009 PrBE  in  4  CPU byte enables.
REQ-010 PrRD  out  32  registered read data to CPU.
REQ-011 PrStall / PrAck / PrErr  out  1 each  CPU freeze / one-cycle completion / one-cycle error.
REQ-012 DevSel  out  NUM_DEV  one-hot device select.
REQ-013 DevAddr  out  WIN_AW  offset within selected window.
REQ-014 DevWD / DevBE / DevWe  out  32 / 4 / 1  latched write data, byte enables, write strobe.
REQ-015 DevReady  in  NUM_DEV  per-device completion.
REQ-016 DevRD  in  NUM_DEV*32  flattened read data, device i at bits [32i+31:32i].
REQ-017 DevIrq  in  NUM_DEV  per-device level interrupts.
REQ-018 HWInt  out  6  CPU interrupt lines [7:2]; bit 2+i = device i; bits at index >= NUM_DEV tied 0.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; encoding implementer's choice.
REQ-020 Hit: PrAddr[31:WIN_AW] equals window index of some device i < NUM_DEV; otherwise miss.
REQ-021 IDLE, PrReq=1 and hit: latch offset, PrWD, PrBE, PrWe, device index; go ACCESS; PrStall=1 combinationally this cycle.
REQ-022 IDLE, PrReq=1 and miss: no DevSel; go DONE with PrErr pending; PrStall=1 this cycle.
REQ-023 ACCESS: DevSel one-hot on latched index, DevWe=latched PrWe, DevAddr/DevWD/DevBE from latches, PrStall=1.
REQ-024 ACCESS and DevReady[sel]=1: capture DevRD[sel] into PrRD (write access captures 0); go DONE.
REQ-025 DevReady of unselected devices ignored.
REQ-026 ACCESS cycle counter, cleared on entry; if TIMEOUT cycles pass without ready: go DONE, PrRD=0, PrErr pending.
REQ-027 Ready on the same cycle timeout expires counts as success, no error.
REQ-028 DONE: PrStall=0, PrAck=1 one cycle, PrErr=1 iff pending; DevSel=0, DevWe=0; PrReq ignored; next state IDLE.
REQ-029 Minimum latency: request cycle + one ACCESS cycle stalled, DONE on third cycle.
REQ-030 PrRD holds value until next capture; PrAck, PrErr high only in DONE.
REQ-031 HWInt[2+i] = synchronised DevIrq[i]; no masking or latching in bridge.

Reset
REQ-032 reset low: state IDLE, counter 0, all latches 0, PrRD=0, PrAck=PrErr=0, DevSel=0, DevWe=0, HWInt=0, synchroniser flops 0.
REQ-033 Reset mid-ACCESS aborts with no PrAck; first post-reset cycle is IDLE.

Configuration
REQ-034 Macro PR_BRIDGE_IRQ_SYNC_EN defined: DevIrq passes a two-flop synchroniser; HWInt lags DevIrq by 2 cycles.
REQ-035 Macro undefined: HWInt[2+i] = DevIrq[i] combinationally, zero latency; all other behaviour identical.

Verification
REQ-036 NUM_DEV=2, read 0x7F14, DevReady[1] high in first ACCESS cycle, DevRD[1]=0xDEADBEEF -> PrStall 2 cycles, 3rd cycle PrAck=1, PrRD=0xDEADBEEF, PrErr=0.
REQ-037 Write 0x7F08, PrWD=0x12345678, PrBE=4'b0011 -> DevSel=2'b01, DevAddr=8, DevWD=0x12345678, DevBE=4'b0011, DevWe=1 until ready; PrAck follows.
REQ-038 Read 0x7F20 (miss, NUM_DEV=2) -> DevSel stays 0, next cycle PrAck=1, PrErr=1, PrRD=0.
REQ-039 TIMEOUT=4, DevReady never asserted -> 4 ACCESS cycles, then PrAck=1, PrErr=1, PrRD=0; ready on 4th cycle instead -> PrErr=0.
REQ-040 Assert reset low during ACCESS -> all outputs 0 immediately, no PrAck; new request after release completes normally.
REQ-041 DevIrq=2'b10 -> HWInt=6'b000010 after 2 cycles with PR_BRIDGE_IRQ_SYNC_EN, same cycle without.

Source files
------------

// File: rtl/pr_bridge.sv
// pr_bridge: CPU-to-peripheral bridge with address decode, access timeout and interrupt routing.
// Optional feature: define PR_BRIDGE_IRQ_SYNC_EN to pass DevIrq through a two-flop synchroniser.
module pr_bridge #(
    parameter int unsigned NUM_DEV   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned WIN_AW    = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    PrReq,
    input  logic                    PrWe,
    input  logic [31:0]             PrAddr,
    input  logic [31:0]             PrWD,
    input  logic [3:0]              PrBE,
    output logic [31:0]             PrRD,
    output logic                    PrStall,
    output logic                    PrAck,
    output logic                    PrErr,
    output logic [NUM_DEV-1:0]      DevSel,
    output logic [WIN_AW-1:0]       DevAddr,
    output logic [31:0]             DevWD,
    output logic [3:0]              DevBE,
    output logic                    DevWe,
    input  logic [NUM_DEV-1:0]      DevReady,
    input  logic [NUM_DEV*32-1:0]   DevRD,
    input  logic [NUM_DEV-1:0]      DevIrq,
    output logic [5:0]              HWInt,
    output logic [1:0]              dbg_state
);

    // CPU handshake: PrReq/PrWe/PrAddr/PrWD/PrBE are held stable while PrStall=1;
    // the access completes in the single cycle where PrAck=1 (with PrErr=1 on miss or timeout).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [2:0]          sel_q, sel_d;
    logic [WIN_AW-1:0]   addr_q, addr_d;
    logic [31:0]         wd_q, wd_d;
    logic [3:0]          be_q, be_d;
    logic                we_q, we_d;
    logic [31:0]         rd_q, rd_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [NUM_DEV-1:0]  dev_sel_q, dev_sel_d;
    logic                dev_we_q, dev_we_d;

    logic                hit;
    logic [2:0]          hit_idx;
    logic [NUM_DEV-1:0]  hit_onehot;
    logic                sel_ready;
    logic [31:0]         sel_rd;

    // Window i occupies the 2^WIN_AW bytes starting at BASE_ADDR + i*2^WIN_AW.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if ((PrAddr >> WIN_AW) == ((BASE_ADDR >> WIN_AW) + 32'(i))) begin
                hit           = 1'b1;
                hit_idx       = 3'(i);
                hit_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rd    = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_q == 3'(i)) begin
                sel_ready = DevReady[i];
                sel_rd    = DevRD[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        be_d      = be_q;
        we_d      = we_q;
        rd_d      = rd_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dev_sel_d = dev_sel_q;
        dev_we_d  = dev_we_q;
        case (state_q)
            ST_IDLE: begin
                if (PrReq) begin
                    if (hit) begin
                        state_d   = ST_ACCESS;
                        cnt_d     = '0;
                        sel_d     = hit_idx;
                        addr_d    = PrAddr[WIN_AW-1:0];
                        wd_d      = PrWD;
                        be_d      = PrBE;
                        we_d      = PrWe;
                        dev_sel_d = hit_onehot;
                        dev_we_d  = PrWe;
                    end else begin
                        state_d = ST_DONE;
                        rd_d    = '0;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready wins over an expiring timeout in the same cycle.
                if (sel_ready) begin
                    state_d   = ST_DONE;
                    rd_d      = we_q ? 32'h0 : sel_rd;
                    ack_d     = 1'b1;
                    dev_sel_d = '0;
                    dev_we_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    rd_d      = '0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    dev_sel_d = '0;
                    dev_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                dev_sel_d = '0;
                dev_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            wd_q      <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dev_sel_q <= '0;
            dev_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            be_q      <= be_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dev_sel_q <= dev_sel_d;
            dev_we_q  <= dev_we_d;
        end
    end

    // Stall must rise in the request cycle itself, so it is decoded from the live PrReq.
    assign PrStall   = reset & (((state_q == ST_IDLE) & PrReq) | (state_q == ST_ACCESS));
    assign PrRD      = rd_q;
    assign PrAck     = ack_q;
    assign PrErr     = err_q;
    assign DevSel    = dev_sel_q;
    assign DevWe     = dev_we_q;
    assign DevAddr   = addr_q;
    assign DevWD     = wd_q;
    assign DevBE     = be_q;
    assign dbg_state = state_q;

    logic [NUM_DEV-1:0] irq_src;
    logic [5:0]         hw_int;

`ifdef PR_BRIDGE_IRQ_SYNC_EN
    logic [NUM_DEV-1:0] irq_sync1_q, irq_sync1_d;
    logic [NUM_DEV-1:0] irq_sync2_q, irq_sync2_d;

    always_comb begin
        irq_sync1_d = DevIrq;
        irq_sync2_d = irq_sync1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_sync1_q <= '0;
            irq_sync2_q <= '0;
        end else begin
            irq_sync1_q <= irq_sync1_d;
            irq_sync2_q <= irq_sync2_d;
        end
    end

    assign irq_src = irq_sync2_q;
`else
    assign irq_src = DevIrq;
`endif

    // HWInt[i] is CPU line 2+i; lines beyond NUM_DEV stay low.
    always_comb begin
        hw_int                = '0;
        hw_int[NUM_DEV-1:0]   = irq_src;
        HWInt                 = reset ? hw_int : 6'h0;
    end

endmodule

// File: tb/tb_pr_bridge.sv
// Directed testbench for pr_bridge (NUM_DEV=2, TIMEOUT=4); honours PR_BRIDGE_IRQ_SYNC_EN.
module tb_pr_bridge;

    logic        clk;
    logic        reset;
    logic        pr_req, pr_we;
    logic [31:0] pr_addr, pr_wd;
    logic [3:0]  pr_be;
    logic [31:0] PrRD;
    logic        PrStall, PrAck, PrErr;
    logic [1:0]  DevSel;
    logic [3:0]  DevAddr;
    logic [31:0] DevWD;
    logic [3:0]  DevBE;
    logic        DevWe;
    logic [1:0]  dev_ready;
    logic [63:0] dev_rd;
    logic [1:0]  dev_irq;
    logic [5:0]  HWInt;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    pr_bridge #(.NUM_DEV(2), .BASE_ADDR(32'h0000_7F00), .WIN_AW(4), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .PrReq(pr_req), .PrWe(pr_we), .PrAddr(pr_addr), .PrWD(pr_wd), .PrBE(pr_be),
        .PrRD(PrRD), .PrStall(PrStall), .PrAck(PrAck), .PrErr(PrErr),
        .DevSel(DevSel), .DevAddr(DevAddr), .DevWD(DevWD), .DevBE(DevBE), .DevWe(DevWe),
        .DevReady(dev_ready), .DevRD(dev_rd), .DevIrq(dev_irq), .HWInt(HWInt),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, state=%0d", dbg_state);
        $fatal(1);
    end

    // Driver tasks: inputs change 1 time unit after the rising edge, checks happen at the falling edge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        pr_req = 1'b1; pr_we = we; pr_addr = addr; pr_wd = wd; pr_be = be;
    endtask

    task automatic test_reset();
        reset = 1'b0; drive_req(1'b1, 32'h7F14, 32'hFFFF_FFFF, 4'hF);
        dev_ready = 2'b11; dev_rd = '0; dev_irq = 2'b11;
        @(negedge clk); @(negedge clk);
        n_tests++; if ({PrStall, PrAck, PrErr, DevWe} !== 4'b0000) begin n_fail++; $display("FAIL rst_ctrl: got stall/ack/err/we=%b exp 0000", {PrStall, PrAck, PrErr, DevWe}); end
        n_tests++; if (DevSel !== 2'b00) begin n_fail++; $display("FAIL rst_devsel: got %b exp 00", DevSel); end
        n_tests++; if (PrRD !== 32'h0) begin n_fail++; $display("FAIL rst_prrd: got %h exp 0", PrRD); end
        n_tests++; if (HWInt !== 6'h0) begin n_fail++; $display("FAIL rst_hwint: got %b exp 000000", HWInt); end
        next_cycle();
        reset = 1'b1; pr_req = 1'b0; dev_ready = 2'b00; dev_irq = 2'b00;
        @(negedge clk);
        n_tests++; if ({PrStall, PrAck} !== 2'b00) begin n_fail++; $display("FAIL rst_idle: got stall/ack=%b exp 00", {PrStall, PrAck}); end
    endtask

    task automatic test_read();
        next_cycle();
        drive_req(1'b0, 32'h7F14, 32'h0, 4'hF); dev_rd[63:32] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++; if ({PrStall, DevSel} !== 3'b100) begin n_fail++; $display("FAIL rd_req: got stall/sel=%b exp 100", {PrStall, DevSel}); end
        next_cycle(); dev_ready = 2'b10;
        @(negedge clk);
        n_tests++; if ({PrStall, PrAck, DevSel, DevWe} !== 5'b10100) begin n_fail++; $display("FAIL rd_access: got stall/ack/sel/we=%b exp 10100", {PrStall, PrAck, DevSel, DevWe}); end
        n_tests++; if (DevAddr !== 4'd4) begin n_fail++; $display("FAIL rd_devaddr: got %0d exp 4", DevAddr); end
        next_cycle(); dev_ready = 2'b00;
        @(negedge clk);
        n_tests++; if ({PrStall, PrAck, PrErr, DevSel} !== 5'b01000) begin n_fail++; $display("FAIL rd_done: got stall/ack/err/sel=%b exp 01000", {PrStall, PrAck, PrErr, DevSel}); end
        n_tests++; if (PrRD !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h exp deadbeef", PrRD); end
        next_cycle(); pr_req = 1'b0;
        @(negedge clk);
        n_tests++; if ({PrAck, PrErr, PrStall} !== 3'b000) begin n_fail++; $display("FAIL rd_after: got ack/err/stall=%b exp 000", {PrAck, PrErr, PrStall}); end
    endtask

    task automatic test_miss();
        next_cycle();
        drive_req(1'b0, 32'h7F20, 32'h0, 4'hF);
        @(negedge clk);
        n_tests++; if ({PrStall, DevSel} !== 3'b100) begin n_fail++; $display("FAIL miss_req: got stall/sel=%b exp 100", {PrStall, DevSel}); end
        next_cycle();
        @(negedge clk);
        n_tests++; if ({PrStall, PrAck, PrErr, DevSel} !== 5'b01100) begin n_fail++; $display("FAIL miss_done: got stall/ack/err/sel=%b exp 01100", {PrStall, PrAck, PrErr, DevSel}); end
        n_tests++; if (PrRD !== 32'h0) begin n_fail++; $display("FAIL miss_prrd: got %h exp 0", PrRD); end
        next_cycle(); pr_req = 1'b0;
        @(negedge clk);
        n_tests++; if ({PrAck, PrErr} !== 2'b00) begin n_fail++; $display("FAIL miss_after: got ack/err=%b exp 00", {PrAck, PrErr}); end
    endtask

    task automatic test_write();
        next_cycle();
        drive_req(1'b1, 32'h7F08, 32'h1234_5678, 4'b0011); dev_rd[31:0] = 32'h5555_AAAA;
        next_cycle(); dev_ready = 2'b10;
        @(negedge clk);
        n_tests++; if ({PrStall, DevSel, DevWe} !== 4'b1011) begin n_fail++; $display("FAIL wr_access: got stall/sel/we=%b exp 1011", {PrStall, DevSel, DevWe}); end
        n_tests++; if ({DevAddr, DevBE} !== {4'd8, 4'b0011}) begin n_fail++; $display("FAIL wr_addr_be: got addr=%0d be=%b exp 8 0011", DevAddr, DevBE); end
        n_tests++; if (DevWD !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_wd: got %h exp 12345678", DevWD); end
        next_cycle(); dev_ready = 2'b01;
        @(negedge clk);
        n_tests++; if ({PrStall, PrAck, DevSel, DevWe} !== 5'b10011) begin n_fail++; $display("FAIL wr_ignore_other: got stall/ack/sel/we=%b exp 10011", {PrStall, PrAck, DevSel, DevWe}); end
        next_cycle(); dev_ready = 2'b00;
        @(negedge clk);
        n_tests++; if ({PrStall, PrAck, PrErr, DevSel, DevWe} !== 6'b010000) begin n_fail++; $display("FAIL wr_done: got stall/ack/err/sel/we=%b exp 010000", {PrStall, PrAck, PrErr, DevSel, DevWe}); end
        n_tests++; if (PrRD !== 32'h0) begin n_fail++; $display("FAIL wr_prrd: got %h exp 0", PrRD); end
        next_cycle(); pr_req = 1'b0;
    endtask

    task automatic test_ready_last();
        next_cycle();
        drive_req(1'b0, 32'h7F04, 32'h0, 4'hF); dev_rd[31:0] = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k == 3) dev_ready = 2'b01;
            @(negedge clk);
            n_tests++; if ({PrStall, PrAck, DevSel} !== 4'b1001) begin n_fail++; $display("FAIL rl_access%0d: got stall/ack/sel=%b exp 1001", k, {PrStall, PrAck, DevSel}); end
        end
        next_cycle(); dev_ready = 2'b00;
        @(negedge clk);
        n_tests++; if ({PrAck, PrErr} !== 2'b10) begin n_fail++; $display("FAIL rl_done: got ack/err=%b exp 10", {PrAck, PrErr}); end
        n_tests++; if (PrRD !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rl_data: got %h exp cafef00d", PrRD); end
        next_cycle(); pr_req = 1'b0;
    endtask

    task automatic test_timeout();
        next_cycle();
        drive_req(1'b0, 32'h7F00, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            n_tests++; if ({PrStall, PrAck, DevSel} !== 4'b1001) begin n_fail++; $display("FAIL to_access%0d: got stall/ack/sel=%b exp 1001", k, {PrStall, PrAck, DevSel}); end
        end
        next_cycle();
        @(negedge clk);
        n_tests++; if ({PrStall, PrAck, PrErr, DevSel} !== 5'b01100) begin n_fail++; $display("FAIL to_done: got stall/ack/err/sel=%b exp 01100", {PrStall, PrAck, PrErr, DevSel}); end
        n_tests++; if (PrRD !== 32'h0) begin n_fail++; $display("FAIL to_prrd: got %h exp 0", PrRD); end
        next_cycle(); pr_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive_req(1'b0, 32'h7F1C, 32'h0, 4'hF); dev_rd[63:32] = 32'h1122_3344; dev_rd[31:0] = 32'h99AA_BBCC;
        next_cycle(); dev_ready = 2'b10;
        next_cycle(); dev_ready = 2'b00; pr_addr = 32'h7F00;
        @(negedge clk);
        n_tests++; if ({PrAck, PrRD} !== {1'b1, 32'h1122_3344}) begin n_fail++; $display("FAIL b2b_first: got ack=%b rd=%h exp 1 11223344", PrAck, PrRD); end
        next_cycle();
        @(negedge clk);
        n_tests++; if ({PrStall, PrAck, DevSel} !== 4'b1000) begin n_fail++; $display("FAIL b2b_second_req: got stall/ack/sel=%b exp 1000", {PrStall, PrAck, DevSel}); end
        next_cycle(); dev_ready = 2'b01;
        next_cycle(); dev_ready = 2'b00;
        @(negedge clk);
        n_tests++; if ({PrAck, PrErr, PrRD} !== {2'b10, 32'h99AA_BBCC}) begin n_fail++; $display("FAIL b2b_second: got ack=%b err=%b rd=%h exp 1 0 99aabbcc", PrAck, PrErr, PrRD); end
        next_cycle(); pr_req = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        next_cycle();
        drive_req(1'b1, 32'h7F18, 32'hA5A5_A5A5, 4'hF);
        next_cycle();
        n_tests++; if ({DevSel, DevWe} !== 3'b101) begin n_fail++; $display("FAIL rm_access: got sel/we=%b exp 101", {DevSel, DevWe}); end
        reset = 1'b0; #1;
        n_tests++; if ({PrStall, PrAck, PrErr, DevSel, DevWe} !== 6'b000000) begin n_fail++; $display("FAIL rm_ctrl: got stall/ack/err/sel/we=%b exp 000000", {PrStall, PrAck, PrErr, DevSel, DevWe}); end
        n_tests++; if ({PrRD, DevWD} !== 64'h0) begin n_fail++; $display("FAIL rm_data: got rd=%h wd=%h exp 0 0", PrRD, DevWD); end
        pr_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clk);
            n_tests++; if ({PrStall, PrAck, DevSel} !== 4'b0000) begin n_fail++; $display("FAIL rm_noack%0d: got stall/ack/sel=%b exp 0000", k, {PrStall, PrAck, DevSel}); end
        end
        next_cycle();
        drive_req(1'b0, 32'h7F10, 32'h0, 4'hF); dev_rd[63:32] = 32'h0BAD_F00D;
        next_cycle(); dev_ready = 2'b10;
        next_cycle(); dev_ready = 2'b00;
        @(negedge clk);
        n_tests++; if ({PrAck, PrErr, PrRD} !== {2'b10, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL rm_recover: got ack=%b err=%b rd=%h exp 1 0 0badf00d", PrAck, PrErr, PrRD); end
        next_cycle(); pr_req = 1'b0;
    endtask

    task automatic test_irq();
        next_cycle();
        dev_irq = 2'b10;
`ifdef PR_BRIDGE_IRQ_SYNC_EN
        @(negedge clk);
        n_tests++; if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL irq_lag0: got %b exp 000000", HWInt); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL irq_lag1: got %b exp 000000", HWInt); end
        next_cycle();
        @(negedge clk);
        n_tests++; if (HWInt !== 6'b000010) begin n_fail++; $display("FAIL irq_lag2: got %b exp 000010", HWInt); end
        next_cycle(); dev_irq = 2'b01;
        next_cycle(); next_cycle();
        @(negedge clk);
        n_tests++; if (HWInt !== 6'b000001) begin n_fail++; $display("FAIL irq_dev0: got %b exp 000001", HWInt); end
`else
        #1;
        n_tests++; if (HWInt !== 6'b000010) begin n_fail++; $display("FAIL irq_dev1: got %b exp 000010", HWInt); end
        dev_irq = 2'b01; #1;
        n_tests++; if (HWInt !== 6'b000001) begin n_fail++; $display("FAIL irq_dev0: got %b exp 000001", HWInt); end
        dev_irq = 2'b11; #1;
        n_tests++; if (HWInt !== 6'b000011) begin n_fail++; $display("FAIL irq_both: got %b exp 000011", HWInt); end
`endif
        dev_irq = 2'b00;
    endtask

    initial begin
        pr_req = 1'b0; pr_we = 1'b0; pr_addr = '0; pr_wd = '0; pr_be = '0;
        dev_ready = '0; dev_rd = '0; dev_irq = '0; reset = 1'b0;
        test_reset();
        test_read();
        test_miss();
        test_write();
        test_ready_last();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
